// File: rtl/hazard5_muldiv_issue_pkg.sv
// Shared RV32M op encodings and result-half decode for the muldiv issue stage and sequencer.
package hazard5_muldiv_issue_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned OP_W         = 3;

  typedef logic [OP_W-1:0] md_op_t;

  localparam md_op_t M_OP_MUL    = 3'd0;
  localparam md_op_t M_OP_MULH   = 3'd1;
  localparam md_op_t M_OP_MULHSU = 3'd2;
  localparam md_op_t M_OP_MULHU  = 3'd3;
  localparam md_op_t M_OP_DIV    = 3'd4;
  localparam md_op_t M_OP_DIVU   = 3'd5;
  localparam md_op_t M_OP_REM    = 3'd6;
  localparam md_op_t M_OP_REMU   = 3'd7;

  // High half carries mulh*/rem*, low half carries mul/div*.
  function automatic logic op_sel_high(input md_op_t op);
    return (op != M_OP_MUL) && (op != M_OP_DIV) && (op != M_OP_DIVU);
  endfunction

  function automatic logic op_is_div(input md_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/hazard5_muldiv_issue_if.sv
// Pipeline-side and sequencer-side signals of the muldiv issue stage.
interface hazard5_muldiv_issue_if #(
  parameter int unsigned XLEN = 32
);
  import hazard5_muldiv_issue_pkg::*;

  logic            x_valid;
  md_op_t          x_op;
  logic [XLEN-1:0] x_a;
  logic [XLEN-1:0] x_b;
  logic            x_flush;
  logic            x_stall;
  logic [XLEN-1:0] x_result;
  logic            x_result_vld;

  md_op_t          md_op;
  logic            md_op_vld;
  logic            md_op_rdy;
  logic            md_op_force;
  logic [XLEN-1:0] md_op_a;
  logic [XLEN-1:0] md_op_b;
  logic [XLEN-1:0] md_result_h;
  logic [XLEN-1:0] md_result_l;
  logic            md_result_vld;

  modport master (
    input  x_valid, x_op, x_a, x_b, x_flush,
    input  md_op_rdy, md_result_h, md_result_l, md_result_vld,
    output x_stall, x_result, x_result_vld,
    output md_op, md_op_vld, md_op_force, md_op_a, md_op_b
  );

  modport slave (
    output x_valid, x_op, x_a, x_b, x_flush,
    output md_op_rdy, md_result_h, md_result_l, md_result_vld,
    input  x_stall, x_result, x_result_vld,
    input  md_op, md_op_vld, md_op_force, md_op_a, md_op_b
  );

endinterface

// File: rtl/hazard5_muldiv_issue.sv
// Execute-stage front end for hazard5_muldiv_seq: issue, stall, half-select and flush/abort.
// Optional HAZARD5_MULDIV_REUSE_EN: fused-pair reuse of the other half of the last result.
module hazard5_muldiv_issue
  import hazard5_muldiv_issue_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  hazard5_muldiv_issue_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  md_op_t          op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] result_q;
  logic            result_vld_q;

  logic            latch_c;
  logic            capture_c;
  logic            reuse_take_c;
  logic            reuse_hit_c;
  logic [XLEN-1:0] reuse_result_c;
  logic            md_op_vld_c;
  logic            md_op_force_c;
  logic            x_stall_c;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    latch_c       = 1'b0;
    capture_c     = 1'b0;
    reuse_take_c  = 1'b0;
    md_op_vld_c   = 1'b0;
    md_op_force_c = 1'b0;
    x_stall_c     = 1'b0;
    if (rst) begin
      state_nxt = S_IDLE;
    end else begin
      x_stall_c = bus.x_valid && !bus.x_flush && (state != S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.x_valid && !bus.x_flush) begin
            if (reuse_hit_c) begin
              reuse_take_c = 1'b1;
              state_nxt    = S_DONE;
            end else begin
              latch_c   = 1'b1;
              state_nxt = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (bus.x_flush) begin
            state_nxt = S_IDLE;
          end else begin
            md_op_vld_c = 1'b1;
            if (bus.md_op_rdy) state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          // Flush wins over a result arriving in the same cycle.
          if (bus.x_flush) begin
            md_op_force_c = 1'b1;
            state_nxt     = S_IDLE;
          end else if (bus.md_result_vld) begin
            capture_c = 1'b1;
            state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Issue operands and the selected result half.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= M_OP_MUL;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
    end else begin
      if (latch_c) begin
        op_q <= bus.x_op;
        a_q  <= bus.x_a;
        b_q  <= bus.x_b;
      end
      if (capture_c) begin
        result_q <= op_sel_high(op_q) ? bus.md_result_h : bus.md_result_l;
      end else if (reuse_take_c) begin
        result_q <= reuse_result_c;
      end
      result_vld_q <= (state_nxt == S_DONE);
    end
  end

`ifdef HAZARD5_MULDIV_REUSE_EN
  logic            reuse_vld_q;
  md_op_t          reuse_op_q;
  logic [XLEN-1:0] reuse_a_q;
  logic [XLEN-1:0] reuse_b_q;
  logic [XLEN-1:0] reuse_h_q;
  logic [XLEN-1:0] reuse_l_q;

  // MUL after any MULH*, or DIV<->REM / DIVU<->REMU, on identical operands.
  always_comb begin
    reuse_hit_c = reuse_vld_q && (bus.x_a == reuse_a_q) && (bus.x_b == reuse_b_q) &&
                  (((bus.x_op == M_OP_MUL) && !op_is_div(reuse_op_q) && (reuse_op_q != M_OP_MUL)) ||
                   (op_is_div(bus.x_op) && op_is_div(reuse_op_q) &&
                    (bus.x_op[0] == reuse_op_q[0]) && (bus.x_op[1] != reuse_op_q[1])));
    reuse_result_c = op_sel_high(bus.x_op) ? reuse_h_q : reuse_l_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reuse_vld_q <= 1'b0;
      reuse_op_q  <= M_OP_MUL;
      reuse_a_q   <= '0;
      reuse_b_q   <= '0;
      reuse_h_q   <= '0;
      reuse_l_q   <= '0;
    end else if (bus.x_flush) begin
      reuse_vld_q <= 1'b0;
    end else if (capture_c) begin
      reuse_vld_q <= 1'b1;
      reuse_op_q  <= op_q;
      reuse_a_q   <= a_q;
      reuse_b_q   <= b_q;
      reuse_h_q   <= bus.md_result_h;
      reuse_l_q   <= bus.md_result_l;
    end
  end
`else
  assign reuse_hit_c    = 1'b0;
  assign reuse_result_c = '0;
`endif

  assign bus.x_stall      = x_stall_c;
  assign bus.x_result     = result_q;
  assign bus.x_result_vld = result_vld_q;
  assign bus.md_op        = op_q;
  assign bus.md_op_vld    = md_op_vld_c;
  assign bus.md_op_force  = md_op_force_c;
  assign bus.md_op_a      = a_q;
  assign bus.md_op_b      = b_q;

endmodule

// File: tb/tb_hazard5_muldiv_issue.sv
// Directed bench for hazard5_muldiv_issue; the bench plays both the X stage and the sequencer.
module tb_hazard5_muldiv_issue;
  import hazard5_muldiv_issue_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  hazard5_muldiv_issue_if #(.XLEN(32)) bus ();

  hazard5_muldiv_issue #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Full issue/wait/done sequence with hand-computed sequencer halves.
  task automatic do_op(input string tag, input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l, input logic [31:0] exp);
    bus.x_valid = 1'b1;
    bus.x_op    = op;
    bus.x_a     = a;
    bus.x_b     = b;
    #1;
    chk1({tag, ".idle_stall"}, bus.x_stall, 1'b1);
    chk1({tag, ".idle_novld"}, bus.md_op_vld, 1'b0);
    tick();
    chk1({tag, ".issue_vld"}, bus.md_op_vld, 1'b1);
    chk({tag, ".issue_op"}, 32'(bus.md_op), 32'(op));
    chk({tag, ".issue_a"}, bus.md_op_a, a);
    chk({tag, ".issue_b"}, bus.md_op_b, b);
    tick();
    chk1({tag, ".issue_hold"}, bus.md_op_vld, 1'b1);
    bus.md_op_rdy = 1'b1;
    tick();
    bus.md_op_rdy = 1'b0;
    #1;
    chk1({tag, ".wait_novld"}, bus.md_op_vld, 1'b0);
    chk1({tag, ".wait_stall"}, bus.x_stall, 1'b1);
    chk({tag, ".wait_a_stable"}, bus.md_op_a, a);
    bus.md_result_vld = 1'b1;
    bus.md_result_h   = h;
    bus.md_result_l   = l;
    tick();
    bus.md_result_vld = 1'b0;
    #1;
    chk1({tag, ".done_vld"}, bus.x_result_vld, 1'b1);
    chk({tag, ".done_result"}, bus.x_result, exp);
    chk1({tag, ".done_nostall"}, bus.x_stall, 1'b0);
    bus.x_valid = 1'b0;
    tick();
    chk1({tag, ".pulse_end"}, bus.x_result_vld, 1'b0);
    chk({tag, ".result_hold"}, bus.x_result, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".x_result"}, bus.x_result, 32'h0);
    chk1({tag, ".x_result_vld"}, bus.x_result_vld, 1'b0);
    chk1({tag, ".x_stall"}, bus.x_stall, 1'b0);
    chk1({tag, ".md_op_vld"}, bus.md_op_vld, 1'b0);
    chk1({tag, ".md_op_force"}, bus.md_op_force, 1'b0);
    chk({tag, ".md_op"}, 32'(bus.md_op), 32'h0);
    chk({tag, ".md_op_a"}, bus.md_op_a, 32'h0);
    chk({tag, ".md_op_b"}, bus.md_op_b, 32'h0);
  endtask

  initial begin
    n_cmp             = 0;
    n_err             = 0;
    rst               = 1'b1;
    bus.x_valid       = 1'b0;
    bus.x_op          = M_OP_MUL;
    bus.x_a           = '0;
    bus.x_b           = '0;
    bus.x_flush       = 1'b0;
    bus.md_op_rdy     = 1'b0;
    bus.md_result_h   = '0;
    bus.md_result_l   = '0;
    bus.md_result_vld = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset");

    do_op("mul_3x4", M_OP_MUL, 32'd3, 32'd4, 32'h0, 32'hC, 32'h0000000C);
    do_op("mulhu_max", M_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE);
    do_op("mulh_min", M_OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 32'h40000000);
    do_op("mulhsu", M_OP_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF);
    do_op("div_by_0", M_OP_DIV, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("rem_neg", M_OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF);
    do_op("divu", M_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 32'd14);
    do_op("remu", M_OP_REMU, 32'd100, 32'd9, 32'd1, 32'd11, 32'd1);

    // Flush in IDLE: nothing is issued.
    bus.x_valid = 1'b1;
    bus.x_op    = M_OP_MUL;
    bus.x_a     = 32'd8;
    bus.x_b     = 32'd8;
    bus.x_flush = 1'b1;
    #1;
    chk1("flush_idle.stall", bus.x_stall, 1'b0);
    tick();
    bus.x_flush = 1'b0;
    bus.x_valid = 1'b0;
    #1;
    chk1("flush_idle.novld", bus.md_op_vld, 1'b0);

    // Flush in ISSUE: request drops in the same cycle.
    bus.x_valid = 1'b1;
    tick();
    chk1("flush_issue.vld", bus.md_op_vld, 1'b1);
    bus.x_flush = 1'b1;
    #1;
    chk1("flush_issue.drop", bus.md_op_vld, 1'b0);
    chk1("flush_issue.force", bus.md_op_force, 1'b0);
    tick();
    bus.x_flush = 1'b0;
    bus.x_valid = 1'b0;
    #1;
    chk1("flush_issue.idle", bus.md_op_vld, 1'b0);
    tick();
    chk1("flush_issue.no_result", bus.x_result_vld, 1'b0);

    // Flush in WAIT with a colliding result: abort pulse, result discarded.
    bus.x_valid = 1'b1;
    bus.x_op    = M_OP_MUL;
    bus.x_a     = 32'd9;
    bus.x_b     = 32'd9;
    tick();
    bus.md_op_rdy = 1'b1;
    tick();
    bus.md_op_rdy = 1'b0;
    tick();
    chk1("flush_wait.no_force_yet", bus.md_op_force, 1'b0);
    bus.x_flush       = 1'b1;
    bus.md_result_vld = 1'b1;
    bus.md_result_h   = 32'h0;
    bus.md_result_l   = 32'd81;
    #1;
    chk1("flush_wait.force", bus.md_op_force, 1'b1);
    chk1("flush_wait.nostall", bus.x_stall, 1'b0);
    tick();
    bus.x_flush       = 1'b0;
    bus.md_result_vld = 1'b0;
    bus.x_valid       = 1'b0;
    #1;
    chk1("flush_wait.force_end", bus.md_op_force, 1'b0);
    chk1("flush_wait.no_result", bus.x_result_vld, 1'b0);
    chk("flush_wait.result_kept", bus.x_result, 32'd1);
    tick();
    chk1("flush_wait.still_idle", bus.x_result_vld, 1'b0);
    do_op("mul_5x6", M_OP_MUL, 32'd5, 32'd6, 32'h0, 32'd30, 32'd30);

    // Late result outside WAIT is ignored.
    bus.md_result_vld = 1'b1;
    bus.md_result_l   = 32'd77;
    tick();
    bus.md_result_vld = 1'b0;
    #1;
    chk1("stray_result.novld", bus.x_result_vld, 1'b0);
    chk("stray_result.kept", bus.x_result, 32'd30);

    // Reset while waiting on the sequencer.
    bus.x_valid = 1'b1;
    bus.x_op    = M_OP_MUL;
    bus.x_a     = 32'd2;
    bus.x_b     = 32'd2;
    tick();
    bus.md_op_rdy = 1'b1;
    tick();
    bus.md_op_rdy = 1'b0;
    bus.x_valid   = 1'b0;
    rst           = 1'b1;
    #1;
    chk1("rst_wait.no_force", bus.md_op_force, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");
    do_op("after_rst", M_OP_MUL, 32'd3, 32'd5, 32'h0, 32'd15, 32'd15);

`ifdef HAZARD5_MULDIV_REUSE_EN
    do_op("reuse_mulhu", M_OP_MULHU, 32'h10000, 32'h10000, 32'h1, 32'h0, 32'h1);
    bus.x_valid = 1'b1;
    bus.x_op    = M_OP_MUL;
    bus.x_a     = 32'h10000;
    bus.x_b     = 32'h10000;
    #1;
    chk1("reuse_mul.stall", bus.x_stall, 1'b1);
    chk1("reuse_mul.novld0", bus.md_op_vld, 1'b0);
    tick();
    chk1("reuse_mul.novld1", bus.md_op_vld, 1'b0);
    chk1("reuse_mul.done", bus.x_result_vld, 1'b1);
    chk("reuse_mul.result", bus.x_result, 32'h0);
    bus.x_valid = 1'b0;
    tick();
    chk1("reuse_mul.pulse_end", bus.x_result_vld, 1'b0);
    do_op("reuse_mulhu2", M_OP_MULHU, 32'h10000, 32'h10000, 32'h1, 32'h0, 32'h1);
    bus.x_flush = 1'b1;
    tick();
    bus.x_flush = 1'b0;
    do_op("reuse_flushed", M_OP_MUL, 32'h10000, 32'h10000, 32'h1, 32'h0, 32'h0);
`else
    do_op("pair_mulhu", M_OP_MULHU, 32'h10000, 32'h10000, 32'h1, 32'h0, 32'h1);
    do_op("pair_mul", M_OP_MUL, 32'h10000, 32'h10000, 32'h1, 32'h0, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
